multicycle_ctrl: RTL and testbench

- Multicycle MIPS control unit: Moore FSM that sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Successor to the single-cycle main decoder. Adds a memory ready handshake, a wait timeout, illegal-opcode trapping, a zero-extend select and a parametrised ALU-op width.
- Sits between the instruction register `op` field and the multicycle datapath muxes and enables.

---
 rtl/multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Moore control FSM for a multicycle MIPS datapath. Sequences one instruction
// at a time through fetch, decode, execute, memory and writeback, waits on a
// memory ready handshake, traps undefined opcodes and memory wait timeouts
// into an absorbing HALT state.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   op           opcode field of the instruction register
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory access request
//   iord         address select (1 = ALUOut, 0 = PC)
//   irwrite      instruction register load enable
//   pcwrite      unconditional PC write
//   branch       01 = beq, 10 = bne, 00 = none
//   pcsrc        00 = ALU, 01 = ALUOut, 10 = jump target
//   alusrca      0 = PC, 1 = rs
//   alusrcb      00 = rt, 01 = 4, 10 = imm, 11 = imm<<2
//   aluop        000 add, 001 sub, 010 funct, 011 and, 100 or (zero-extended)
//   zeroext      1 = zero-extend immediate
//   regdst       1 = rd, 0 = rt
//   memtoreg     1 = memory data, 0 = ALUOut
//   regwrite     register file write enable
//   memwrite     memory write enable
//   illegal_op   sticky: an undefined opcode was trapped
//   mem_timeout  sticky: a memory wait expired
//   state        current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int ALUOP_W        = 3,
   parameter bit MEM_HANDSHAKE  = 1'b1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               iord,
   output logic               irwrite,
   output logic               pcwrite,
   output logic [1:0]         branch,
   output logic [1:0]         pcsrc,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [ALUOP_W-1:0] aluop,
   output logic               zeroext,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               memwrite,
   output logic               illegal_op,
   output logic               mem_timeout,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_IMMEX   = 4'd9,
      S_IMMWB   = 4'd10,
      S_JUMP    = 4'd11,
      S_HALT    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b011);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b100);

   // The counter only has to reach TIMEOUT_CYCLES-1 before the timeout fires.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               rdy;
   logic               waiting;
   logic               set_illegal;
   logic               set_timeout;

   // Without the handshake every memory access completes in one cycle.
   assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign state = state_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FETCH;
         cnt_q       <= '0;
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            cnt_q <= '0;
         else if (waiting && !rdy)
            cnt_q <= cnt_q + 1'b1;
         if (set_illegal) illegal_op  <= 1'b1;
         if (set_timeout) mem_timeout <= 1'b1;
      end
   end

   // NOTE: every signal driven here gets a default before the case, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      waiting     = 1'b0;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      mem_req     = 1'b0;
      iord        = 1'b0;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      branch      = 2'b00;
      pcsrc       = 2'b00;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      aluop       = ALU_ADD;
      zeroext     = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      memwrite    = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            waiting = 1'b1;
            if (rdy) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_RTYPE:                state_d = S_RTYPEEX;
               OP_LW, OP_SW:            state_d = S_MEMADR;
               OP_BEQ, OP_BNE:          state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
               OP_J:                    state_d = S_JUMP;
               default: begin
                  state_d     = S_HALT;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            waiting = 1'b1;
            if (rdy) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
            waiting  = 1'b1;
            if (rdy) state_d = S_FETCH;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALU_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = ALU_SUB;
            pcsrc   = 2'b01;
            branch  = (op == OP_BNE) ? 2'b10 : 2'b01;
            state_d = S_FETCH;
         end
         S_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            case (op)
               OP_ANDI: begin aluop = ALU_AND; zeroext = 1'b1; end
               OP_ORI:  begin aluop = ALU_OR;  zeroext = 1'b1; end
               default: aluop = ALU_ADD;
            endcase
            state_d = S_IMMWB;
         end
         S_IMMWB: begin
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pcwrite = 1'b1;
            pcsrc   = 2'b10;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase

      // A ready in the final allowed cycle still wins over the timeout.
      if (TIMEOUT_CYCLES > 0 && waiting && !rdy && cnt_q == CNT_LAST) begin
         state_d     = S_HALT;
         set_timeout = 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl with default parameters (3-bit aluop,
// handshake enabled, 16-cycle timeout). Inputs change 1 ns after the rising
// edge; outputs are checked 1 ns later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       mem_ready;
   logic       mem_req, iord, irwrite, pcwrite;
   logic [1:0] branch, pcsrc, alusrcb;
   logic       alusrca;
   logic [2:0] aluop;
   logic       zeroext, regdst, memtoreg, regwrite, memwrite;
   logic       illegal_op, mem_timeout;
   logic [3:0] state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .iord        (iord),
      .irwrite     (irwrite),
      .pcwrite     (pcwrite),
      .branch      (branch),
      .pcsrc       (pcsrc),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .aluop       (aluop),
      .zeroext     (zeroext),
      .regdst      (regdst),
      .memtoreg    (memtoreg),
      .regwrite    (regwrite),
      .memwrite    (memwrite),
      .illegal_op  (illegal_op),
      .mem_timeout (mem_timeout),
      .state       (state)
   );

   task automatic check(input string tag, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("reset_state", 32'(state), 32'd0);
      check("reset_flags", 32'({illegal_op, mem_timeout}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      op        = 6'b000000;
      mem_ready = 1'b0;
      #3;
      do_reset();

      // ---- R-type: 0,1,6,7,0 ----
      op = 6'b000000; mem_ready = 1'b1; #1;
      check("rt_fetch_state", 32'(state), 32'd0);
      check("rt_fetch_ctl", 32'({mem_req, irwrite, pcwrite, alusrcb, aluop}),
            32'({1'b1, 1'b1, 1'b1, 2'b01, 3'b000}));
      tick();
      check("rt_decode_state", 32'(state), 32'd1);
      check("rt_decode_alusrcb", 32'(alusrcb), 32'd3);
      tick();
      check("rt_ex_state", 32'(state), 32'd6);
      check("rt_ex_ctl", 32'({alusrca, aluop}), 32'({1'b1, 3'b010}));
      tick();
      check("rt_wb_state", 32'(state), 32'd7);
      check("rt_wb_ctl", 32'({regdst, regwrite, memtoreg}), 32'({1'b1, 1'b1, 1'b0}));
      tick();
      check("rt_back_fetch", 32'(state), 32'd0);

      // ---- lw with 2 wait cycles in MEMRD: 0,1,2,3,3,3,4,0 ----
      op = 6'b100011; mem_ready = 1'b1;
      tick();
      check("lw_decode", 32'(state), 32'd1);
      tick();
      check("lw_memadr", 32'(state), 32'd2);
      check("lw_memadr_ctl", 32'({alusrca, alusrcb, aluop}), 32'({1'b1, 2'b10, 3'b000}));
      tick();
      mem_ready = 1'b0; #1;
      check("lw_memrd0", 32'(state), 32'd3);
      check("lw_memrd_ctl", 32'({mem_req, iord, regwrite, memtoreg}),
            32'({1'b1, 1'b1, 1'b0, 1'b0}));
      tick();
      check("lw_memrd1", 32'(state), 32'd3);
      tick();
      mem_ready = 1'b1; #1;
      check("lw_memrd2", 32'(state), 32'd3);
      tick();
      check("lw_memwb", 32'(state), 32'd4);
      check("lw_memwb_ctl", 32'({memtoreg, regwrite, mem_req}), 32'({1'b1, 1'b1, 1'b0}));
      tick();
      check("lw_back_fetch", 32'(state), 32'd0);

      // ---- andi ----
      op = 6'b001100;
      tick();
      tick();
      check("andi_immex", 32'(state), 32'd9);
      check("andi_ctl", 32'({aluop, zeroext, alusrca, alusrcb}),
            32'({3'b011, 1'b1, 1'b1, 2'b10}));
      tick();
      check("andi_immwb", 32'({state, regwrite}), 32'({4'd10, 1'b1}));
      tick();

      // ---- bne ----
      op = 6'b000101;
      tick();
      tick();
      check("bne_state", 32'(state), 32'd8);
      check("bne_ctl", 32'({branch, aluop, pcsrc, alusrca}),
            32'({2'b10, 3'b001, 2'b01, 1'b1}));
      tick();
      check("bne_back_fetch", 32'(state), 32'd0);

      // ---- j ----
      op = 6'b000010;
      tick();
      tick();
      check("j_ctl", 32'({state, pcwrite, pcsrc}), 32'({4'd11, 1'b1, 2'b10}));
      tick();
      check("j_back_fetch", 32'(state), 32'd0);

      // ---- sw, then reset mid-MEMWR ----
      op = 6'b101011;
      tick();
      tick();
      tick();
      mem_ready = 1'b0; #1;
      check("sw_memwr", 32'({state, mem_req, iord, memwrite}),
            32'({4'd5, 1'b1, 1'b1, 1'b1}));
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_memwrite", 32'(memwrite), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // ---- illegal opcode ----
      op = 6'b111111; mem_ready = 1'b1;
      tick();
      check("ill_decode", 32'(state), 32'd1);
      tick();
      check("ill_halt", 32'({state, illegal_op}), 32'({4'd15, 1'b1}));
      for (int i = 0; i < 20; i++) begin
         tick();
         check("ill_halt_enables",
               32'({state, mem_req, irwrite, pcwrite, regwrite, memwrite, branch, pcsrc}),
               32'({4'd15, 9'd0}));
      end
      do_reset();

      // ---- timeout in FETCH ----
      mem_ready = 1'b0; op = 6'b000000; #1;
      check("to_fetch_irwrite", 32'({irwrite, pcwrite}), 32'd0);
      for (int i = 0; i < 15; i++) begin
         tick();
         check("to_still_fetch", 32'({state, mem_timeout}), 32'({4'd0, 1'b0}));
      end
      tick();
      check("to_halt", 32'({state, mem_timeout}), 32'({4'd15, 1'b1}));
      do_reset();

      // ---- ready on the 16th cycle wins ----
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      mem_ready = 1'b1; #1;
      check("late_ready_fetch", 32'({state, irwrite}), 32'({4'd0, 1'b1}));
      tick();
      check("late_ready_decode", 32'({state, mem_timeout}), 32'({4'd1, 1'b0}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
